fp_match_engine: RTL and testbench
==================================

Name: fp_match_engine

Overview:
- Fingerprint comparison stage directly downstream of the key/command state block.
- Consumes the 2-bit `fp_start` command and reports busy status on `fp_state`.
- Streams a stored template image and the probe image out of their synchronous RAMs and popcounts overlapping ridge pixels.
- Outputs the score, the winning template index and a match flag for the LCD result display.

Parameters:
- DATA_W, 8, pixels per RAM word (1 bit per binarized pixel).
- WORDS, 512, RAM words per image (64x64 image = 4096 pixels).
- ADDR_W, 9, RAM word address width; must satisfy 2**ADDR_W >= WORDS.
- MATCH_TH, 1024, minimum score for a match (inclusive).
- SCORE_W, 13, score width; must hold WORDS*DATA_W (localparam computed in the package).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active low.
- fp_start  in  2  command: 00 none, 01 compare vs template 0, 10 vs template 1, 11 vs both.
- fp_state  out  1  busy; high from command accept until the DONE state exits.
- tpl_sel  out  1  template bank select for the template RAM read.
- tpl_addr  out  ADDR_W  template RAM word address.
- tpl_rdata  in  DATA_W  template RAM data; valid 1 cycle after the address.
- probe_addr  out  ADDR_W  probe RAM word address; always equal to tpl_addr.
- probe_rdata  in  DATA_W  probe RAM data; valid 1 cycle after the address.
- score  out  SCORE_W  final score (best score for command 11).
- match_idx  out  1  template index that produced `score`.
- match  out  1  score >= MATCH_TH.
- done  out  1  single-cycle pulse when the results are updated.

Behaviour:
- Reset: one clock is used. Reset is synchronous and active-low: `rst_n` low at a clk edge forces the reset state.
  - All outputs go to 0 and the FSM goes to IDLE.
  - Reset wins over any other event, including mid-pass; a partial accumulation is discarded.
- FSM states: IDLE, RUN, DRAIN, SWITCH, DONE, HOLD.
- IDLE:
  - A command is accepted at the edge where fp_start != 00.
  - On accept: latch the command into cmd_r, set tpl_sel = (cmd==10), zero the accumulator, set addr = 0, set fp_state = 1, go to RUN.
- RUN:
  - addr increments each cycle, 0 .. WORDS-1.
  - A 2-stage valid pipeline follows the address: stage 1 is RAM data; stage 2 computes popcount(tpl_rdata & probe_rdata) and adds it to acc.
  - At addr == WORDS-1, go to DRAIN.
  - Address holds at WORDS-1; it never wraps during a pass.
- DRAIN:
  - Lasts 2 cycles, until the last word is accumulated.
  - It then goes to SWITCH if cmd_r==11 and this was pass 0; otherwise it goes to DONE.
  - A pass is WORDS+2 cycles from the first address to the final accumulate.
- SWITCH (1 cycle):
  - Store acc as score0, clear acc, set tpl_sel = 1, set addr = 0, go to RUN.
- DONE (1 cycle):
  - Register score, match_idx and match, and pulse `done`.
  - Single template: score = acc, match_idx = tpl_sel.
  - Dual: score = max(score0, acc); match_idx = 1 only if acc > score0, so a tie selects 0.
  - Go to HOLD.
- HOLD:
  - fp_state = 0.
  - Wait for fp_start == 00, then go to IDLE. This prevents a held level command from retriggering.
- fp_start changes while in RUN, DRAIN or SWITCH are ignored.
- Result outputs hold their last values until the next DONE.
- Timing: command sampled at edge E0.
  - Single pass: done is high in cycle E0 + WORDS + 4.
  - Dual: done is high in cycle E0 + 2*WORDS + 7.
  - fp_state falls on the cycle after done.
- Arithmetic:
  - The accumulator is SCORE_W bits and unsigned; it cannot overflow because the maximum value is WORDS*DATA_W.
  - Popcount is a DATA_W-input adder tree, registered in pipeline stage 2.

Decomposition:
- Package fp_pkg:
  - FSM state enum.
  - Command encodings CMD_NONE/CMD_T0/CMD_T1/CMD_BOTH.
  - SCORE_W localparam function clog2(WORDS*DATA_W + 1).
- Sub-module fp_popcount: parameterised DATA_W popcount, purely combinational.
  - The parent registers its output.

Test Plan:
- Params WORDS=16, DATA_W=8, MATCH_TH=64. All words are 0xFF in both RAMs, fp_start=01 held -> done at E0+20, score=128, match=1, match_idx=0. Exactly one done occurs while fp_start stays 01; a new accept happens only after fp_start returns to 00.
- Template 1 = 0xAA, probe = 0xFF, cmd 10 -> score=64, match=1, match_idx=1. Template 1 = 0x0F, probe = 0xF0 -> score=0, match=0.
- cmd 11, template 0 score 40, template 1 score 90 -> done at E0+39, score=90, match_idx=1. With equal scores of 50 -> score=50, match_idx=0, match=0.
- Pulse rst_n low at cycle 8 of RUN -> next cycle fp_state=0, done=0, score=0, tpl_addr=0. A fresh command then yields the correct full-image score.
- Toggle fp_start 01 -> 10 -> 00 during RUN -> ignored; result uses template 0 and tpl_sel stays 0 throughout.
- Address check: tpl_addr == probe_addr every cycle, and the sequence is 0..15 with no wrap. Popcount check with a per-word random pattern against a reference model sum.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the fingerprint match engine.
package fp_pkg;

  // Controller states: one pass is RUN then DRAIN; a dual compare inserts SWITCH between passes.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SWITCH = 3'd3,
    ST_DONE   = 3'd4,
    ST_HOLD   = 3'd5
  } fp_state_e;

  // fp_start command encodings.
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_T0   = 2'b01;
  localparam logic [1:0] CMD_T1   = 2'b10;
  localparam logic [1:0] CMD_BOTH = 2'b11;

  // Default geometry: 64x64 binarized image, 8 pixels per RAM word.
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WORDS    = 512;
  localparam int DEF_ADDR_W   = 9;
  localparam int DEF_MATCH_TH = 1024;

  // Width needed to hold a score of every pixel overlapping (WORDS*DATA_W).
  function automatic int score_width(input int words, input int data_w);
    return $clog2(words * data_w + 1);
  endfunction

  localparam int DEF_SCORE_W = score_width(DEF_WORDS, DEF_DATA_W);

endpackage

// File: rtl/fp_match_engine_if.sv
// Command, RAM read and result signals of the match engine.
interface fp_match_engine_if
  import fp_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int SCORE_W = DEF_SCORE_W
);

  logic [1:0]         fp_start;
  logic               fp_state;
  logic               tpl_sel;
  logic [ADDR_W-1:0]  tpl_addr;
  logic [DATA_W-1:0]  tpl_rdata;
  logic [ADDR_W-1:0]  probe_addr;
  logic [DATA_W-1:0]  probe_rdata;
  logic [SCORE_W-1:0] score;
  logic               match_idx;
  logic               match;
  logic               done;

  // Command source, image RAMs and result display side.
  modport master (
    output fp_start, tpl_rdata, probe_rdata,
    input  fp_state, tpl_sel, tpl_addr, probe_addr, score, match_idx, match, done
  );

  // The match engine itself.
  modport slave (
    input  fp_start, tpl_rdata, probe_rdata,
    output fp_state, tpl_sel, tpl_addr, probe_addr, score, match_idx, match, done
  );

endinterface

// File: rtl/fp_popcount.sv
// Combinational population count built as a balanced binary adder tree.
module fp_popcount #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data,
  output logic [CNT_W-1:0]  count
);

  // Leaves are padded to a power of two so the tree is a simple heap:
  // node k sums nodes 2k and 2k+1, node 1 is the root.
  localparam int LEAVES = 1 << $clog2(DATA_W);

  logic [CNT_W-1:0] node [1:2*LEAVES-1];

  for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
    if (gi < DATA_W) begin : g_bit
      assign node[LEAVES+gi] = CNT_W'(data[gi]);
    end else begin : g_pad
      assign node[LEAVES+gi] = '0;
    end
  end

  for (genvar gi = 1; gi < LEAVES; gi++) begin : g_sum
    assign node[gi] = node[2*gi] + node[2*gi+1];
  end

  assign count = node[1];

endmodule

// File: rtl/fp_match_engine.sv
// Streams a template and the probe image from synchronous RAMs, popcounts the
// overlapping ridge pixels and reports the (best) score and match decision.
module fp_match_engine
  import fp_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WORDS    = DEF_WORDS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MATCH_TH = DEF_MATCH_TH,
  parameter int SCORE_W  = score_width(WORDS, DATA_W)
) (
  input logic          clk,
  input logic          rst_n,
  fp_match_engine_if.slave bus
);

  localparam int                CNT_W     = $clog2(DATA_W + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  // One extra bit so a threshold above the largest score never matches.
  localparam logic [SCORE_W:0]  THRESH    = (SCORE_W + 1)'(MATCH_TH);

  fp_state_e          state_q, state_d;
  logic [1:0]         cmd_q, cmd_d;
  logic               tpl_sel_q, tpl_sel_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               pass_q, pass_d;      // 0: first pass, 1: second pass of a dual compare
  logic               drain_q, drain_d;    // second DRAIN cycle marker
  logic               v1_q, v1_d;          // RAM data valid this cycle
  logic               v2_q, v2_d;          // popcount register valid this cycle
  logic [CNT_W-1:0]   pc_q, pc_d;
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic [SCORE_W-1:0] score0_q, score0_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               match_idx_q, match_idx_d;
  logic               match_q, match_d;
  logic               done_q, done_d;
  logic               fp_state_q, fp_state_d;

  logic [DATA_W-1:0]  overlap_w;
  logic [CNT_W-1:0]   pc_w;
  logic [SCORE_W-1:0] result_w;
  logic               result_idx_w;

  // Ridge pixels present in both images for the word currently on the RAM outputs.
  assign overlap_w = bus.tpl_rdata & bus.probe_rdata;

  fp_popcount #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_popcount (
    .data  (overlap_w),
    .count (pc_w)
  );

  // State register and all datapath flops; reset discards any partial pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_NONE;
      tpl_sel_q   <= 1'b0;
      addr_q      <= '0;
      pass_q      <= 1'b0;
      drain_q     <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      pc_q        <= '0;
      acc_q       <= '0;
      score0_q    <= '0;
      score_q     <= '0;
      match_idx_q <= 1'b0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
      fp_state_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      tpl_sel_q   <= tpl_sel_d;
      addr_q      <= addr_d;
      pass_q      <= pass_d;
      drain_q     <= drain_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      score0_q    <= score0_d;
      score_q     <= score_d;
      match_idx_q <= match_idx_d;
      match_q     <= match_d;
      done_q      <= done_d;
      fp_state_q  <= fp_state_d;
    end
  end

  // Next-state logic; fp_start is only looked at in IDLE and HOLD.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.fp_start != CMD_NONE) state_d = ST_RUN;
      ST_RUN:    if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
      ST_DRAIN:  if (drain_q) state_d = (cmd_q == CMD_BOTH && !pass_q) ? ST_SWITCH : ST_DONE;
      ST_SWITCH: state_d = ST_RUN;
      ST_DONE:   state_d = ST_HOLD;
      ST_HOLD:   if (bus.fp_start == CMD_NONE) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Result selection: a dual compare keeps template 0 on a tie.
  always_comb begin
    result_w     = acc_q;
    result_idx_w = tpl_sel_q;
    if (cmd_q == CMD_BOTH) begin
      if (acc_q > score0_q) begin
        result_w     = acc_q;
        result_idx_w = 1'b1;
      end else begin
        result_w     = score0_q;
        result_idx_w = 1'b0;
      end
    end
  end

  // Output and datapath updates per state, plus the free-running read pipeline.
  always_comb begin
    cmd_d       = cmd_q;
    tpl_sel_d   = tpl_sel_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    drain_d     = 1'b0;
    score0_d    = score0_q;
    score_d     = score_q;
    match_idx_d = match_idx_q;
    match_d     = match_q;
    done_d      = 1'b0;
    fp_state_d  = fp_state_q;
    // Each RUN cycle issues one address; its data arrives next cycle and is
    // popcounted into pc_q, which is added to the accumulator one cycle later.
    v1_d        = (state_q == ST_RUN);
    v2_d        = v1_q;
    pc_d        = pc_w;
    acc_d       = v2_q ? (acc_q + SCORE_W'(pc_q)) : acc_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.fp_start != CMD_NONE) begin
          cmd_d      = bus.fp_start;
          tpl_sel_d  = (bus.fp_start == CMD_T1);
          acc_d      = '0;
          addr_d     = '0;
          pass_d     = 1'b0;
          fp_state_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (addr_q != LAST_ADDR) addr_d = addr_q + 1'b1;
      end
      ST_DRAIN: begin
        drain_d = ~drain_q;
      end
      ST_SWITCH: begin
        score0_d  = acc_q;
        acc_d     = '0;
        tpl_sel_d = 1'b1;
        addr_d    = '0;
        pass_d    = 1'b1;
      end
      ST_DONE: begin
        score_d     = result_w;
        match_idx_d = result_idx_w;
        match_d     = ({1'b0, result_w} >= THRESH);
        done_d      = 1'b1;
      end
      ST_HOLD: begin
        fp_state_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.fp_state   = fp_state_q;
  assign bus.tpl_sel    = tpl_sel_q;
  assign bus.tpl_addr   = addr_q;
  assign bus.probe_addr = addr_q;
  assign bus.score      = score_q;
  assign bus.match_idx  = match_idx_q;
  assign bus.match      = match_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_fp_match_engine.sv
// Directed bench for fp_match_engine with a pass-level model and a per-cycle compare process.
// Cycle numbering: "cycle E0+n" is the clock period that ends at edge E0+n,
// where E0 is the edge that samples the command.
module tb_fp_match_engine;
  import fp_pkg::*;

  localparam int W   = 16;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int TH  = 64;
  localparam int SW  = score_width(W, DW);

  logic clk;
  logic rst_n;

  fp_match_engine_if #(.DATA_W(DW), .ADDR_W(AW), .SCORE_W(SW)) bus ();

  fp_match_engine #(
    .DATA_W   (DW),
    .WORDS    (W),
    .ADDR_W   (AW),
    .MATCH_TH (TH),
    .SCORE_W  (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Image RAMs with one cycle read latency.
  logic [DW-1:0] tpl_mem   [0:1][0:W-1];
  logic [DW-1:0] probe_mem [0:W-1];

  always @(posedge clk) begin
    bus.tpl_rdata   <= tpl_mem[bus.tpl_sel][bus.tpl_addr];
    bus.probe_rdata <= probe_mem[bus.probe_addr];
  end

  int checks = 0;
  int errors = 0;

  // Model state shared between driver and monitor.
  int         edge_cnt = 0;
  bit         pending  = 1'b0;
  int         e0       = 0;
  logic [1:0] exp_cmd  = 2'b00;
  int         exp_score, exp_idx, exp_match;
  int         held_score = 0, held_idx = 0, held_match = 0;
  int         last_addr = 0, last_sel = 0;
  int         done_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Overlap score of one template against the probe, straight from the image contents.
  function automatic int pass_score(input int t);
    int s = 0;
    for (int w = 0; w < W; w++) s += $countones(tpl_mem[t][w] & probe_mem[w]);
    return s;
  endfunction

  // Per-cycle comparison against the model, 1 time unit after each rising edge.
  int k, dk, ea, es;
  always @(posedge clk) begin
    edge_cnt = edge_cnt + 1;
    #1;
    chk("addr_equal", int'(bus.tpl_addr), int'(bus.probe_addr));
    if (!rst_n) begin
      chk("rst_fp_state", bus.fp_state, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_score", int'(bus.score), 0);
      chk("rst_idx", bus.match_idx, 0);
      chk("rst_match", bus.match, 0);
      chk("rst_addr", int'(bus.tpl_addr), 0);
      chk("rst_sel", bus.tpl_sel, 0);
      held_score = 0; held_idx = 0; held_match = 0;
      last_addr = 0; last_sel = 0;
    end else if (pending) begin
      k  = edge_cnt - e0 + 1;
      dk = (exp_cmd == CMD_BOTH) ? 2 * W + 7 : W + 4;
      if (exp_cmd != CMD_BOTH || k <= W + 3) ea = k - 1;
      else ea = k - W - 4;
      if (ea > W - 1) ea = W - 1;
      if (exp_cmd == CMD_T1) es = 1;
      else if (exp_cmd == CMD_BOTH && k >= W + 4) es = 1;
      else es = 0;
      chk("busy_fp_state", bus.fp_state, 1);
      chk("busy_addr", int'(bus.tpl_addr), ea);
      chk("busy_tpl_sel", bus.tpl_sel, es);
      chk("done_timing", bus.done, int'(k == dk));
      last_addr = ea; last_sel = es;
      if (k == dk && bus.done) begin
        chk("res_score", int'(bus.score), exp_score);
        chk("res_idx", bus.match_idx, exp_idx);
        chk("res_match", bus.match, exp_match);
        held_score = exp_score; held_idx = exp_idx; held_match = exp_match;
        done_cyc = k;
        pending = 1'b0;
      end else begin
        chk("hold_score", int'(bus.score), held_score);
        chk("hold_idx", bus.match_idx, held_idx);
        chk("hold_match", bus.match, held_match);
      end
    end else begin
      chk("idle_fp_state", bus.fp_state, 0);
      chk("idle_done", bus.done, 0);
      chk("idle_score", int'(bus.score), held_score);
      chk("idle_idx", bus.match_idx, held_idx);
      chk("idle_match", bus.match, held_match);
      chk("idle_addr", int'(bus.tpl_addr), last_addr);
      chk("idle_sel", bus.tpl_sel, last_sel);
    end
  end

  task automatic fill_all(input logic [7:0] t0, input logic [7:0] t1, input logic [7:0] p);
    for (int w = 0; w < W; w++) begin
      tpl_mem[0][w] = t0; tpl_mem[1][w] = t1; probe_mem[w] = p;
    end
  endtask

  task automatic fill_random();
    for (int w = 0; w < W; w++) begin
      tpl_mem[0][w] = 8'($urandom_range(0, 255));
      tpl_mem[1][w] = 8'($urandom_range(0, 255));
      probe_mem[w]  = 8'($urandom_range(0, 255));
    end
  endtask

  // Release the command for one edge (lets HOLD return to IDLE), then present cmd.
  task automatic issue(input logic [1:0] cmd);
    int s0, s1;
    @(negedge clk);
    bus.fp_start = CMD_NONE;
    @(negedge clk);
    s0 = pass_score(0);
    s1 = pass_score(1);
    if (cmd == CMD_T0) begin exp_score = s0; exp_idx = 0; end
    else if (cmd == CMD_T1) begin exp_score = s1; exp_idx = 1; end
    else if (s1 > s0) begin exp_score = s1; exp_idx = 1; end
    else begin exp_score = s0; exp_idx = 0; end
    exp_match = int'(exp_score >= TH);
    exp_cmd   = cmd;
    e0        = edge_cnt + 1;
    pending   = 1'b1;
    bus.fp_start = cmd;
  endtask

  task automatic wait_done();
    int n = 0;
    while (pending && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (pending) begin
      chk("done_timeout", 0, 1);
      pending = 1'b0;
    end
  endtask

  // Wait at negedges until the current period is cycle E0+target.
  task automatic wait_cycle(input int target);
    int n = 0;
    while ((edge_cnt - e0 + 1) < target && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.fp_start = CMD_NONE;
    fill_all(8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("lit_reset_score", int'(bus.score), 0);
    chk("lit_reset_busy", bus.fp_state, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full overlap on template 0, command held high afterwards.
    fill_all(8'hFF, 8'hFF, 8'hFF);
    issue(CMD_T0);
    wait_done();
    chk("lit_t0_score", int'(bus.score), 128);
    chk("lit_t0_match", bus.match, 1);
    chk("lit_t0_idx", bus.match_idx, 0);
    chk("lit_t0_done_cycle", done_cyc, 20);
    repeat (10) @(negedge clk);
    chk("lit_held_cmd_idle", bus.fp_state, 0);

    // Template 1 at exactly the threshold.
    fill_all(8'h00, 8'hAA, 8'hFF);
    issue(CMD_T1);
    wait_done();
    chk("lit_t1_score", int'(bus.score), 64);
    chk("lit_t1_match", bus.match, 1);
    chk("lit_t1_idx", bus.match_idx, 1);

    // Disjoint pixels.
    fill_all(8'h00, 8'h0F, 8'hF0);
    issue(CMD_T1);
    wait_done();
    chk("lit_zero_score", int'(bus.score), 0);
    chk("lit_zero_match", bus.match, 0);

    // Dual compare: 40 vs 90.
    fill_all(8'h00, 8'h00, 8'hFF);
    for (int w = 0; w < 5; w++) tpl_mem[0][w] = 8'hFF;
    for (int w = 0; w < 11; w++) tpl_mem[1][w] = 8'hFF;
    tpl_mem[1][11] = 8'h03;
    issue(CMD_BOTH);
    wait_done();
    chk("lit_dual_score", int'(bus.score), 90);
    chk("lit_dual_idx", bus.match_idx, 1);
    chk("lit_dual_done_cycle", done_cyc, 39);

    // Dual compare tie at 50: template 0 wins, below threshold.
    fill_all(8'h00, 8'h00, 8'hFF);
    for (int w = 0; w < 6; w++) tpl_mem[0][w] = 8'hFF;
    tpl_mem[0][6] = 8'h03;
    for (int w = 10; w < 16; w++) tpl_mem[1][w] = 8'hFF;
    tpl_mem[1][0] = 8'hC0;
    issue(CMD_BOTH);
    wait_done();
    chk("lit_tie_score", int'(bus.score), 50);
    chk("lit_tie_idx", bus.match_idx, 0);
    chk("lit_tie_match", bus.match, 0);

    // Reset in the middle of a pass, then a fresh compare.
    fill_random();
    issue(CMD_T0);
    wait_cycle(8);
    rst_n = 1'b0;
    bus.fp_start = CMD_NONE;
    pending = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("lit_midrst_busy", bus.fp_state, 0);
    chk("lit_midrst_done", bus.done, 0);
    chk("lit_midrst_score", int'(bus.score), 0);
    chk("lit_midrst_addr", int'(bus.tpl_addr), 0);
    issue(CMD_T0);
    wait_done();
    chk("after_rst_score", int'(bus.score), pass_score(0));

    // Command changes during RUN are ignored.
    fill_random();
    issue(CMD_T0);
    wait_cycle(4);
    bus.fp_start = CMD_T1;
    wait_cycle(8);
    bus.fp_start = CMD_NONE;
    wait_done();
    chk("lit_toggle_idx", bus.match_idx, 0);

    // Random images through both single and dual commands.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      issue(CMD_BOTH);
      wait_done();
      fill_random();
      issue(CMD_T1);
      wait_done();
    end

    @(negedge clk);
    bus.fp_start = CMD_NONE;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
